// File: rtl/bicubic_out_packer_pkg.sv
// Shared widths, serializer state type and byte-select helper for the
// bicubic output packer.
package bicubic_out_packer_pkg;

   localparam int PIX_W        = 8;
   localparam int PIX_PER_WORD = 4;
   localparam int WORD_W       = PIX_W * PIX_PER_WORD;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } ser_state_t;

   // Byte 0 sits in the low bits, matching the {in_3,in_2,in_1,in_0} packing.
   function automatic logic [PIX_W-1:0] pick_pix(input logic [WORD_W-1:0] word,
                                                 input logic [1:0] idx);
      return word[int'(idx)*PIX_W +: PIX_W];
   endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO; rdata is the head word, valid whenever empty is low.
module packer_fifo
   import bicubic_out_packer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int WORD_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WORD_W-1:0]        wdata,
   output logic [WORD_W-1:0]        rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              do_push;
   logic              do_pop;

   // Acceptance looks only at the registered count, so a same-cycle pop
   // never makes room for a write.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bicubic_out_packer.sv
// Buffers 4-pixel groups from the interpolator and streams them out one byte
// per handshake, flagging the last pixel of each output line.
module bicubic_out_packer
   import bicubic_out_packer_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int LINE_PIX = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic [PIX_W-1:0]         in_0,
   input  logic [PIX_W-1:0]         in_1,
   input  logic [PIX_W-1:0]         in_2,
   input  logic [PIX_W-1:0]         in_3,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [PIX_W-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_eol,
   output ser_state_t               state
);

   localparam int LW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;

   logic [WORD_W-1:0] rdata;
   logic [WORD_W-1:0] word;
   logic              fifo_empty;
   logic              pop;
   logic              hs;
   logic              last_byte;
   logic [1:0]        b;
   logic [LW-1:0]     line_cnt;

   packer_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (in_valid),
      .pop   (pop),
      .wdata ({in_3, in_2, in_1, in_0}),
      .rdata (rdata),
      .level (level),
      .full  (full),
      .empty (fifo_empty)
   );

   assign out_valid = (state == S_SEND);
   assign hs        = out_valid & out_ready;
   assign last_byte = (b == 2'd3);
   assign out_eol   = out_valid & (line_cnt == LW'(LINE_PIX-1));

   // Refill in the same edge that retires byte 3, so words stream without a bubble.
   assign pop = ~fifo_empty & ((state == S_IDLE) | (hs & last_byte));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         word     <= '0;
         b        <= '0;
         out_data <= '0;
         line_cnt <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         state    <= S_IDLE;
         word     <= '0;
         b        <= '0;
         out_data <= '0;
         line_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (in_valid & full) overflow <= 1'b1;

         if (hs) begin
            line_cnt <= (line_cnt == LW'(LINE_PIX-1)) ? '0 : line_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (pop) begin
                  word     <= rdata;
                  out_data <= pick_pix(rdata, 2'd0);
                  b        <= 2'd0;
                  state    <= S_SEND;
               end
            end
            S_SEND: begin
               if (hs) begin
                  if (!last_byte) begin
                     b        <= b + 2'd1;
                     out_data <= pick_pix(word, b + 2'd1);
                  end else if (pop) begin
                     word     <= rdata;
                     out_data <= pick_pix(rdata, 2'd0);
                     b        <= 2'd0;
                  end else begin
                     b     <= 2'd0;
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
